// File: rtl/mem_scan_pkg.sv
// Shared encodings for the memory scan unit: scan modes, FSM states and a
// small elaboration-time helper.
package mem_scan_pkg;

    typedef enum logic [1:0] {
        MODE_MAX = 2'd0,
        MODE_MIN = 2'd1,
        MODE_CNT = 2'd2,
        MODE_RSV = 2'd3
    } scan_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_scan_ram.sv
// Simple dual-port storage: one write port, one synchronous read port with
// a single cycle of read latency. Contents are never reset.
module mem_scan_ram
    import mem_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             Clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mem_scan_unit.sv
// Scans a window of the internal memory and reports its maximum, minimum or
// the number of words equal to a key, with wrap-around addressing.
module mem_scan_unit
    import mem_scan_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 64,
    localparam int AW = $clog2(DEPTH),
    localparam int RW = max_int(WIDTH, AW + 1)
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             wr,
    input  logic [AW-1:0]    AB,
    input  logic [WIDTH-1:0] DB,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    base,
    input  logic [AW:0]      len,
    input  logic [WIDTH-1:0] key,
    output logic             busy,
    output logic             done,
    output logic [RW-1:0]    result,
    output logic [AW-1:0]    res_addr
);

    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    scan_state_t state, state_nx;

    scan_mode_t       mode_q;
    logic [WIDTH-1:0] key_q;
    logic [AW:0]      total_q;
    logic [AW:0]      issued_q;
    logic [AW-1:0]    addr_q;

    logic             rvalid_q;
    logic [AW-1:0]    raddr_q;
    logic [WIDTH-1:0] rdata;

    logic             have_q, have_nx;
    logic [WIDTH-1:0] best_q, best_nx;
    logic [AW-1:0]    best_addr_q, best_addr_nx;
    logic [AW:0]      count_q, count_nx;

    logic [AW:0]      len_eff;
    logic             last_issue;
    logic             ram_we;
    logic             issuing;
    logic             is_min;
    logic             is_cnt;
    logic             take;

    mem_scan_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .Clk   (Clk),
        .we    (ram_we),
        .waddr (AB),
        .wdata (DB),
        .raddr (addr_q),
        .rdata (rdata)
    );

    // A zero length, or any length past the end of memory, means one full pass.
    always_comb begin
        len_eff = len;
        if ((len == '0) || (len > DEPTH_W)) begin
            len_eff = DEPTH_W;
        end
    end

    assign last_issue = (issued_q == (total_q - CNT_ONE));
    assign is_min     = (mode_q == MODE_MIN);
    assign is_cnt     = (mode_q == MODE_CNT);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SCAN;
            SCAN:    if (last_issue) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == DONE);
        ram_we  = wr && (state == IDLE);
        issuing = (state == SCAN);
    end

    // Strict comparisons keep the earliest address on ties; the first datum always seeds.
    always_comb begin
        take = 1'b0;
        if (!have_q) begin
            take = 1'b1;
        end else if (is_min) begin
            take = (rdata < best_q);
        end else begin
            take = (rdata > best_q);
        end
    end

    always_comb begin
        have_nx      = have_q;
        best_nx      = best_q;
        best_addr_nx = best_addr_q;
        count_nx     = count_q;
        if (rvalid_q) begin
            have_nx = 1'b1;
            if (take) begin
                best_nx      = rdata;
                best_addr_nx = raddr_q;
            end
            if (rdata == key_q) begin
                count_nx = count_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mode_q      <= MODE_MAX;
            key_q       <= '0;
            total_q     <= '0;
            issued_q    <= '0;
            addr_q      <= '0;
            rvalid_q    <= 1'b0;
            raddr_q     <= '0;
            have_q      <= 1'b0;
            best_q      <= '0;
            best_addr_q <= '0;
            count_q     <= '0;
            result      <= '0;
            res_addr    <= '0;
        end else begin
            rvalid_q <= issuing;
            raddr_q  <= addr_q;

            if ((state == IDLE) && start) begin
                mode_q      <= scan_mode_t'(mode);
                key_q       <= key;
                total_q     <= len_eff;
                issued_q    <= '0;
                addr_q      <= base;
                have_q      <= 1'b0;
                best_q      <= '0;
                best_addr_q <= '0;
                count_q     <= '0;
            end

            if (issuing) begin
                addr_q   <= addr_q + ADDR_ONE;
                issued_q <= issued_q + CNT_ONE;
            end

            if ((state == SCAN) || (state == DRAIN)) begin
                have_q      <= have_nx;
                best_q      <= best_nx;
                best_addr_q <= best_addr_nx;
                count_q     <= count_nx;
            end

            // The last datum arrives in DRAIN, so the reported values are taken from the merge path.
            if (state == DRAIN) begin
                result   <= is_cnt ? RW'(count_nx) : RW'(best_nx);
                res_addr <= is_cnt ? '0 : best_addr_nx;
            end
        end
    end

endmodule

// File: tb/tb_mem_scan_unit.sv
// Directed bench for mem_scan_unit: a table of scans over a known memory image
// followed by hand-written sequences for resets, blocked writes and restarts.
module tb_mem_scan_unit;

    logic       Clk;
    logic       Rst;
    logic       wr;
    logic [5:0] AB;
    logic [7:0] DB;
    logic       start;
    logic [1:0] mode;
    logic [5:0] base;
    logic [6:0] len;
    logic [7:0] key;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic [5:0] res_addr;

    int total;
    int bad;

    typedef struct {
        string      name;
        logic [1:0] mode;
        logic [5:0] base;
        logic [6:0] len;
        logic [7:0] key;
        int         exp_cyc;
        int         exp_res;
        int         exp_addr;
    } vec_t;

    vec_t vecs[9];

    mem_scan_unit #(
        .WIDTH(8),
        .DEPTH(64)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .wr       (wr),
        .AB       (AB),
        .DB       (DB),
        .start    (start),
        .mode     (mode),
        .base     (base),
        .len      (len),
        .key      (key),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .res_addr (res_addr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic writeWord(input logic [5:0] a, input logic [7:0] d);
        wr = 1'b1;
        AB = a;
        DB = d;
        tick();
        wr = 1'b0;
    endtask

    // Starts a scan and waits for done; optionally pokes a write or a second start mid-scan.
    task automatic applyStimulus(input logic [1:0] m, input logic [5:0] b, input logic [6:0] l,
                                 input logic [7:0] k, input int wr_at, input int start_at,
                                 output int cyc);
        start = 1'b1;
        mode  = m;
        base  = b;
        len   = l;
        key   = k;
        tick();
        start = 1'b0;
        wr    = 1'b0;
        cyc   = 1;
        checkOutput("busy_after_start", busy, 1);
        while (!done && cyc < 200) begin
            if (cyc == wr_at) begin
                wr = 1'b1;
                AB = 6'd0;
                DB = 8'd5;
            end
            if (cyc == start_at) begin
                start = 1'b1;
                mode  = 2'd0;
                base  = 6'd0;
                len   = 7'd0;
            end
            tick();
            wr    = 1'b0;
            start = 1'b0;
            cyc++;
        end
        checkOutput("done_seen", done, 1);
        checkOutput("busy_with_done", busy, 1);
        tick();
        checkOutput("done_one_cycle", done, 0);
        checkOutput("idle_after_done", busy, 0);
    endtask

    initial begin
        int cyc;
        int extra_done;

        total = 0;
        bad   = 0;
        Rst   = 1'b0;
        wr    = 1'b0;
        AB    = '0;
        DB    = '0;
        start = 1'b0;
        mode  = '0;
        base  = '0;
        len   = '0;
        key   = '0;

        vecs[0] = '{"max_full",      2'd0, 6'd0,  7'd0,   8'd0, 66, 64, 63};
        vecs[1] = '{"min_wrap",      2'd1, 6'd60, 7'd8,   8'd0, 10, 1,  0};
        vecs[2] = '{"max_wrap",      2'd0, 6'd60, 7'd8,   8'd0, 10, 64, 63};
        vecs[3] = '{"min_single",    2'd1, 6'd5,  7'd1,   8'd0, 3,  6,  5};
        vecs[4] = '{"cnt_one",       2'd2, 6'd0,  7'd0,   8'd7, 66, 1,  0};
        vecs[5] = '{"cnt_none",      2'd2, 6'd0,  7'd0,   8'd0, 66, 0,  0};
        vecs[6] = '{"reserved_max",  2'd3, 6'd10, 7'd4,   8'd0, 6,  14, 13};
        vecs[7] = '{"len_overlong",  2'd1, 6'd32, 7'd100, 8'd0, 66, 1,  0};
        vecs[8] = '{"min_wrap_two",  2'd1, 6'd63, 7'd2,   8'd0, 4,  1,  0};

        tick();
        tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_result", result, 0);
        checkOutput("reset_res_addr", res_addr, 0);
        Rst = 1'b1;
        tick();

        for (int i = 0; i < 64; i++) begin
            writeWord(6'(i), 8'(i + 1));
        end

        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].mode, vecs[i].base, vecs[i].len, vecs[i].key, -1, -1, cyc);
            checkOutput({vecs[i].name, "_cycle"}, cyc, vecs[i].exp_cyc);
            checkOutput({vecs[i].name, "_result"}, result, vecs[i].exp_res);
            checkOutput({vecs[i].name, "_addr"}, res_addr, vecs[i].exp_addr);
        end

        $display("[TB] count with ties and a blocked write");
        writeWord(6'd10, 8'd5);
        writeWord(6'd40, 8'd5);
        applyStimulus(2'd2, 6'd0, 7'd0, 8'd5, 10, -1, cyc);
        checkOutput("cnt_tie_cycle", cyc, 66);
        checkOutput("cnt_tie_result", result, 3);
        checkOutput("cnt_tie_addr", res_addr, 0);
        applyStimulus(2'd1, 6'd0, 7'd1, 8'd0, -1, -1, cyc);
        checkOutput("blocked_write_mem0", result, 1);
        writeWord(6'd10, 8'd11);
        writeWord(6'd40, 8'd41);

        $display("[TB] max tie-break");
        writeWord(6'd3, 8'hFF);
        writeWord(6'd7, 8'hFF);
        applyStimulus(2'd0, 6'd0, 7'd16, 8'd0, -1, -1, cyc);
        checkOutput("tie_cycle", cyc, 18);
        checkOutput("tie_result", result, 8'hFF);
        checkOutput("tie_addr", res_addr, 3);
        writeWord(6'd3, 8'd4);
        writeWord(6'd7, 8'd8);

        $display("[TB] reset mid-scan");
        start = 1'b1;
        mode  = 2'd0;
        base  = 6'd0;
        len   = 7'd0;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 20) begin
            tick();
            cyc++;
        end
        #2;
        Rst = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", result, 0);
        checkOutput("abort_res_addr", res_addr, 0);
        tick();
        checkOutput("abort_no_done", done, 0);
        Rst = 1'b1;
        applyStimulus(2'd0, 6'd0, 7'd0, 8'd0, -1, -1, cyc);
        checkOutput("post_reset_cycle", cyc, 66);
        checkOutput("post_reset_result", result, 64);
        checkOutput("post_reset_addr", res_addr, 63);

        $display("[TB] start while busy");
        applyStimulus(2'd1, 6'd60, 7'd8, 8'd0, -1, 5, cyc);
        checkOutput("restart_cycle", cyc, 10);
        checkOutput("restart_result", result, 1);
        checkOutput("restart_addr", res_addr, 0);
        extra_done = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) extra_done++;
            tick();
        end
        checkOutput("restart_extra_done", extra_done, 0);

        $display("[TB] write and start in the same cycle");
        wr = 1'b1;
        AB = 6'd20;
        DB = 8'd200;
        applyStimulus(2'd0, 6'd16, 7'd8, 8'd0, -1, -1, cyc);
        checkOutput("wr_start_cycle", cyc, 10);
        checkOutput("wr_start_result", result, 200);
        checkOutput("wr_start_addr", res_addr, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_scan_unit.md
MEM_SCAN_UNIT -- requirements
Module: mem_scan_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 64: number of words, a power of two, at least 4.
REQ-003 SHALL derive localparam AW = $clog2(DEPTH), and RW = max(WIDTH, AW+1) as the result width.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have these ports:
- Clk  in  1: clock, rising edge.
- Rst  in  1: asynchronous active-low reset.
- wr  in  1: write strobe.
- AB  in  AW: write address.
- DB  in  WIDTH: write data.
- start  in  1: scan request.
- mode  in  2: 0 = MAX, 1 = MIN, 2 = COUNT_EQ, 3 = reserved (behaves as MAX).
- base  in  AW: first scan address.
- len  in  AW+1: number of words to scan; 0 means DEPTH.
- key  in  WIDTH: compare value for COUNT_EQ.
- busy  out  1: scan in progress.
- done  out  1: one-cycle completion pulse.
- result  out  RW: MAX/MIN value (zero-extended) or match count.
- res_addr  out  AW: address of the reported MAX/MIN word; 0 in COUNT_EQ mode.

Function
REQ-006 SHALL write DB to mem[AB] on a rising Clk edge when wr=1 and busy=0.
- wr is ignored while busy=1.
REQ-007 SHALL sample start, mode, base, len and key only in IDLE.
- start while busy=1 is ignored.
- Sampled values are held internally for the whole scan.
REQ-008 SHALL use the FSM states IDLE, SCAN, DRAIN, DONE.
- IDLE->SCAN on start.
- SCAN->DRAIN after the last address is issued.
- DRAIN->DONE after the last datum is accumulated.
- DONE->IDLE unconditionally.
REQ-009 SHALL issue one read address per cycle in SCAN: (base+k) mod DEPTH for k = 0..N-1, where N = len (or DEPTH when len=0).
- Memory read latency is exactly one cycle.
REQ-010 SHALL make busy=1 from the cycle after the start edge through the cycle done is high.
- With the start edge as cycle 0, done SHALL be high for exactly one cycle, in cycle N+2.
REQ-011 In MAX/MIN mode, SHALL report the extreme unsigned value.
- On ties, SHALL report the address encountered first in scan order.
REQ-012 In COUNT_EQ mode, SHALL report the number of words equal to key, from 0 to DEPTH inclusive, with no saturation needed.
REQ-013 SHALL update result and res_addr only in the DONE cycle.
- Both SHALL hold until the DONE cycle of the next scan.
REQ-014 SHALL handle address wrap-around: base+k beyond DEPTH-1 wraps to 0.
- len > DEPTH SHALL be treated as DEPTH.
REQ-015 SHALL treat a wr and a start in the same IDLE cycle as follows: the write completes, and the scan observes the written value.

Reset
REQ-016 SHALL, when Rst=0, immediately force:
- FSM to IDLE,
- busy=0, done=0, result=0, res_addr=0,
- all internal accumulators and counters to 0.
REQ-017 SHALL abort a scan in progress on reset, with no done pulse.
- Memory contents SHALL NOT be reset or altered.
REQ-018 SHALL accept a new start in the first cycle after Rst deasserts.

Structure
REQ-019 SHALL place the following in shared package mem_scan_pkg:
- the mode encodings (MODE_MAX, MODE_MIN, MODE_CNT),
- the FSM state encoding.
REQ-020 SHALL implement the storage as sub-module mem_scan_ram.
- Parameters: WIDTH and DEPTH.
- One write port and one synchronous read port.
- Uninitialised, with no reset.

Verification
REQ-021 SHALL cover a full MAX scan.
- Stimulus: load mem[i] = i+1 for i = 0..63; MAX with base=0, len=0.
- Response: done in cycle 66; result = 64; res_addr = 63.
REQ-022 SHALL cover a wrapped MIN scan.
- Stimulus: same contents; MIN with base=60, len=8.
- Response: done in cycle 10; result = 1; res_addr = 0.
REQ-023 SHALL cover COUNT_EQ with ties and a blocked write.
- Stimulus: additionally write mem[10]=5 and mem[40]=5; COUNT_EQ with key=5, len=0; assert wr to mem[0]=5 mid-scan.
- Response: result = 3 (entries 4, 10, 40); mem[0] stays 1.
REQ-024 SHALL cover MAX tie-breaking.
- Stimulus: mem[3]=mem[7]=0xFF; MAX with base=0, len=16.
- Response: result = 0xFF; res_addr = 3.
REQ-025 SHALL cover reset mid-scan.
- Stimulus: pull Rst low in cycle 20 of a 64-word scan.
- Response: busy=0 and done=0 at once; a scan started afterwards matches REQ-021.
REQ-026 SHALL cover start while busy.
- Stimulus: pulse start again in cycle 5 of a scan.
- Response: exactly one done; the parameters of the first scan are used.
